// File: rtl/perf_counter_bank.sv
// perf_counter_bank: ten independent WIDTH-bit performance counters read by
// the IO intercept. Hit/miss/branch events are level- or edge-counted
// (EVENT_EDGE), stall inputs are always level-counted. Each counter has its
// own clear strobe, which beats any coincident increment.
// Optional feature macro: PERF_CNT_SATURATE_EN -- when defined, counters
// saturate at all-ones instead of wrapping modulo 2^WIDTH.
module perf_counter_bank #(
  parameter int WIDTH      = 16,
  parameter int EVENT_EDGE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_en,
  input  logic             br_event,
  input  logic             br_mispredict_event,
  input  logic             icache_hit_event,
  input  logic             icache_miss_event,
  input  logic             dcache_hit_event,
  input  logic             dcache_miss_event,
  input  logic             l2_hit_event,
  input  logic             l2_miss_event,
  input  logic             if_stall,
  input  logic             mem_stall,
  input  logic             br_count_reset,
  input  logic             br_mispredict_count_reset,
  input  logic             icache_hit_count_reset,
  input  logic             icache_miss_count_reset,
  input  logic             dcache_hit_count_reset,
  input  logic             dcache_miss_count_reset,
  input  logic             l2_hit_count_reset,
  input  logic             l2_miss_count_reset,
  input  logic             if_stall_count_reset,
  input  logic             mem_stall_count_reset,
  output logic [WIDTH-1:0] br_count,
  output logic [WIDTH-1:0] br_mispredict_count,
  output logic [WIDTH-1:0] icache_hit_count,
  output logic [WIDTH-1:0] icache_miss_count,
  output logic [WIDTH-1:0] dcache_hit_count,
  output logic [WIDTH-1:0] dcache_miss_count,
  output logic [WIDTH-1:0] l2_hit_count,
  output logic [WIDTH-1:0] l2_miss_count,
  output logic [WIDTH-1:0] if_stall_count,
  output logic [WIDTH-1:0] mem_stall_count
);

  localparam int NUM_CNT  = 10;
  localparam int NUM_EDGE = 8;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef PERF_CNT_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
`endif

  // Counter index order: 0 br, 1 br_mispredict, 2 icache_hit, 3 icache_miss,
  // 4 dcache_hit, 5 dcache_miss, 6 l2_hit, 7 l2_miss, 8 if_stall, 9 mem_stall.
  logic [NUM_EDGE-1:0] edge_in_s;
  logic [NUM_EDGE-1:0] event_prev_r;
  logic [NUM_CNT-1:0]  ev_s;
  logic [NUM_CNT-1:0]  inc_s;
  logic [NUM_CNT-1:0]  clr_s;
  logic [WIDTH-1:0]    count_r [NUM_CNT];
  logic [WIDTH-1:0]    next_s  [NUM_CNT];

  assign edge_in_s = {l2_miss_event, l2_hit_event, dcache_miss_event, dcache_hit_event,
                      icache_miss_event, icache_hit_event, br_mispredict_event, br_event};

  assign clr_s = {mem_stall_count_reset, if_stall_count_reset, l2_miss_count_reset,
                  l2_hit_count_reset, dcache_miss_count_reset, dcache_hit_count_reset,
                  icache_miss_count_reset, icache_hit_count_reset,
                  br_mispredict_count_reset, br_count_reset};

  // Qualify each event: edge or level detection for hit/miss/branch, level for stalls.
  always_comb begin
    ev_s = {NUM_CNT{1'b0}};
    if (EVENT_EDGE != 0) begin
      ev_s[NUM_EDGE-1:0] = edge_in_s & ~event_prev_r;
    end else begin
      ev_s[NUM_EDGE-1:0] = edge_in_s;
    end
    ev_s[8] = if_stall;
    ev_s[9] = mem_stall;
    inc_s   = ev_s & {NUM_CNT{count_en}};
  end

  // Next count per counter: clear beats increment, increment wraps or saturates.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      next_s[i] = count_r[i];
      if (clr_s[i]) begin
        next_s[i] = ZERO_C;
      end else if (inc_s[i]) begin
`ifdef PERF_CNT_SATURATE_EN
        if (count_r[i] == MAX_C) begin
          next_s[i] = MAX_C;
        end else begin
          next_s[i] = count_r[i] + ONE_C;
        end
`else
        next_s[i] = count_r[i] + ONE_C;
`endif
      end else begin
        next_s[i] = count_r[i];
      end
    end
  end

  // Counter and edge-history registers; prev tracks inputs even while count_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_prev_r <= {NUM_EDGE{1'b0}};
      for (int i = 0; i < NUM_CNT; i++) begin
        count_r[i] <= ZERO_C;
      end
    end else begin
      event_prev_r <= edge_in_s;
      for (int i = 0; i < NUM_CNT; i++) begin
        count_r[i] <= next_s[i];
      end
    end
  end

  assign br_count            = count_r[0];
  assign br_mispredict_count = count_r[1];
  assign icache_hit_count    = count_r[2];
  assign icache_miss_count   = count_r[3];
  assign dcache_hit_count    = count_r[4];
  assign dcache_miss_count   = count_r[5];
  assign l2_hit_count        = count_r[6];
  assign l2_miss_count       = count_r[7];
  assign if_stall_count      = count_r[8];
  assign mem_stall_count     = count_r[9];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a level-mode and an edge-mode instance share
// the same stimulus; a table of directed vectors, a long preload for the
// overflow boundary, and random traffic checked against a counting model.
module tb_perf_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [9:0] ev;
  logic [9:0] clr;
  logic [9:0][15:0] c0;
  logic [9:0][15:0] c1;

  int errors = 0;
  int checks = 0;
  bit check_all = 1'b1;

  string nm [10] = '{"br", "brm", "ih", "im", "dh", "dm", "l2h", "l2m", "ifs", "mems"};

  perf_counter_bank #(.WIDTH(16), .EVENT_EDGE(0)) dut_lvl (
    .clk(clk), .reset(rst), .count_en(en),
    .br_event(ev[0]), .br_mispredict_event(ev[1]),
    .icache_hit_event(ev[2]), .icache_miss_event(ev[3]),
    .dcache_hit_event(ev[4]), .dcache_miss_event(ev[5]),
    .l2_hit_event(ev[6]), .l2_miss_event(ev[7]),
    .if_stall(ev[8]), .mem_stall(ev[9]),
    .br_count_reset(clr[0]), .br_mispredict_count_reset(clr[1]),
    .icache_hit_count_reset(clr[2]), .icache_miss_count_reset(clr[3]),
    .dcache_hit_count_reset(clr[4]), .dcache_miss_count_reset(clr[5]),
    .l2_hit_count_reset(clr[6]), .l2_miss_count_reset(clr[7]),
    .if_stall_count_reset(clr[8]), .mem_stall_count_reset(clr[9]),
    .br_count(c0[0]), .br_mispredict_count(c0[1]),
    .icache_hit_count(c0[2]), .icache_miss_count(c0[3]),
    .dcache_hit_count(c0[4]), .dcache_miss_count(c0[5]),
    .l2_hit_count(c0[6]), .l2_miss_count(c0[7]),
    .if_stall_count(c0[8]), .mem_stall_count(c0[9])
  );

  perf_counter_bank #(.WIDTH(16), .EVENT_EDGE(1)) dut_edg (
    .clk(clk), .reset(rst), .count_en(en),
    .br_event(ev[0]), .br_mispredict_event(ev[1]),
    .icache_hit_event(ev[2]), .icache_miss_event(ev[3]),
    .dcache_hit_event(ev[4]), .dcache_miss_event(ev[5]),
    .l2_hit_event(ev[6]), .l2_miss_event(ev[7]),
    .if_stall(ev[8]), .mem_stall(ev[9]),
    .br_count_reset(clr[0]), .br_mispredict_count_reset(clr[1]),
    .icache_hit_count_reset(clr[2]), .icache_miss_count_reset(clr[3]),
    .dcache_hit_count_reset(clr[4]), .dcache_miss_count_reset(clr[5]),
    .l2_hit_count_reset(clr[6]), .l2_miss_count_reset(clr[7]),
    .if_stall_count_reset(clr[8]), .mem_stall_count_reset(clr[9]),
    .br_count(c1[0]), .br_mispredict_count(c1[1]),
    .icache_hit_count(c1[2]), .icache_miss_count(c1[3]),
    .dcache_hit_count(c1[4]), .dcache_miss_count(c1[5]),
    .l2_hit_count(c1[6]), .l2_miss_count(c1[7]),
    .if_stall_count(c1[8]), .mem_stall_count(c1[9])
  );

  // Reference model: plain integer counts; index 0 = level instance, 1 = edge instance.
  int m_cnt [2][10];
  bit m_prev [8];

  function automatic int bump(int v);
`ifdef PERF_CNT_SATURATE_EN
    return (v >= 65535) ? 65535 : v + 1;
`else
    return (v + 1) % 65536;
`endif
  endfunction

  task automatic model_update(bit r, bit e, logic [9:0] evv, logic [9:0] cl);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        bit counted;
        if (i >= 8 || d == 0) counted = evv[i];
        else counted = evv[i] && !m_prev[i];
        if (r) m_cnt[d][i] = 0;
        else if (cl[i]) m_cnt[d][i] = 0;
        else if (e && counted) m_cnt[d][i] = bump(m_cnt[d][i]);
      end
    end
    for (int i = 0; i < 8; i++) m_prev[i] = r ? 1'b0 : evv[i];
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: model follows the inputs applied at the edge; outputs sampled on negedge.
  task automatic step();
    @(posedge clk);
    model_update(rst, en, ev, clr);
    @(negedge clk);
    if (check_all) begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("model_lvl_%s", nm[i]), c0[i], 16'(m_cnt[0][i]));
        chk($sformatf("model_edg_%s", nm[i]), c1[i], 16'(m_cnt[1][i]));
      end
    end
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [9:0]  ev;
    logic [9:0]  clr;
    int          idx;
    logic [15:0] e_lvl;
    logic [15:0] e_edg;
  } vec_t;

  vec_t tbl [$];

  task automatic add(bit r, bit e, logic [9:0] evv, logic [9:0] cl, int idx,
                     logic [15:0] el, logic [15:0] ee);
    vec_t v;
    v.rst = r; v.en = e; v.ev = evv; v.clr = cl; v.idx = idx; v.e_lvl = el; v.e_edg = ee;
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] wrap_exp;
    rst = 1'b1; en = 1'b1; ev = 10'h000; clr = 10'h000;
    @(negedge clk);

    // Reset with every event high.
    add(1'b1, 1'b1, 10'h3FF, 10'h000, 0, 16'd0, 16'd0);
    // if_stall high five cycles, then low; mem_stall never moves.
    for (int i = 1; i <= 5; i++) add(1'b0, 1'b1, 10'h100, 10'h000, 8, 16'(i), 16'(i));
    add(1'b0, 1'b1, 10'h000, 10'h000, 8, 16'd5, 16'd5);
    add(1'b0, 1'b1, 10'h000, 10'h000, 9, 16'd0, 16'd0);
    // icache_hit pulses to 7, then clear with coincident event, then a pulse.
    for (int i = 1; i <= 7; i++) begin
      add(1'b0, 1'b1, 10'h004, 10'h000, 2, 16'(i), 16'(i));
      add(1'b0, 1'b1, 10'h000, 10'h000, 2, 16'(i), 16'(i));
    end
    add(1'b0, 1'b1, 10'h004, 10'h004, 2, 16'd0, 16'd0);
    add(1'b0, 1'b1, 10'h000, 10'h000, 2, 16'd0, 16'd0);
    add(1'b0, 1'b1, 10'h004, 10'h000, 2, 16'd1, 16'd1);
    // Clear held three cycles against a level stall: stays 0 throughout.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 10'h100, 10'h100, 8, 16'd0, 16'd0);
    // dcache_miss high 4, low 1, high 1.
    add(1'b0, 1'b1, 10'h020, 10'h000, 5, 16'd1, 16'd1);
    add(1'b0, 1'b1, 10'h020, 10'h000, 5, 16'd2, 16'd1);
    add(1'b0, 1'b1, 10'h020, 10'h000, 5, 16'd3, 16'd1);
    add(1'b0, 1'b1, 10'h020, 10'h000, 5, 16'd4, 16'd1);
    add(1'b0, 1'b1, 10'h000, 10'h000, 5, 16'd4, 16'd1);
    add(1'b0, 1'b1, 10'h020, 10'h000, 5, 16'd5, 16'd2);
    // count_en low while br toggles ten cycles, ending high; then re-enable.
    for (int i = 0; i < 10; i++)
      add(1'b0, 1'b0, (i % 2 == 1) ? 10'h001 : 10'h000, 10'h000, 0, 16'd0, 16'd0);
    add(1'b0, 1'b1, 10'h001, 10'h000, 0, 16'd1, 16'd0);
    add(1'b0, 1'b1, 10'h001, 10'h000, 0, 16'd2, 16'd0);
    // Clear on br while l2_hit and l2_miss both count in the same cycle.
    add(1'b0, 1'b1, 10'h0C1, 10'h001, 0, 16'd0, 16'd0);
    add(1'b0, 1'b1, 10'h000, 10'h000, 6, 16'd1, 16'd1);
    add(1'b0, 1'b1, 10'h000, 10'h000, 7, 16'd1, 16'd1);
    // Reset mid-operation beats events.
    add(1'b1, 1'b1, 10'h3FF, 10'h000, 2, 16'd0, 16'd0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; en = tbl[k].en; ev = tbl[k].ev; clr = tbl[k].clr;
      step();
      chk($sformatf("vec%0d_lvl_%s", k, nm[tbl[k].idx]), c0[tbl[k].idx], tbl[k].e_lvl);
      chk($sformatf("vec%0d_edg_%s", k, nm[tbl[k].idx]), c1[tbl[k].idx], tbl[k].e_edg);
    end

    // Preload to 0xFFFE with every input held high, then two more cycles.
    rst = 1'b0; en = 1'b1; clr = 10'h000; ev = 10'h000;
    step();
    check_all = 1'b0;
    ev = 10'h3FF;
    for (int i = 0; i < 65534; i++) step();
    check_all = 1'b1;
    for (int i = 0; i < 10; i++) chk($sformatf("preload_lvl_%s", nm[i]), c0[i], 16'hFFFE);
    chk("preload_edg_br", c1[0], 16'h0001);
    chk("preload_edg_ifs", c1[8], 16'hFFFE);
    step();
    step();
`ifdef PERF_CNT_SATURATE_EN
    wrap_exp = 16'hFFFF;
`else
    wrap_exp = 16'h0000;
`endif
    for (int i = 0; i < 10; i++) chk($sformatf("overflow_lvl_%s", nm[i]), c0[i], wrap_exp);
    chk("overflow_edg_mems", c1[9], wrap_exp);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 10; i++) begin
        ev[i]  = ($urandom_range(0, 2) != 0);
        clr[i] = ($urandom_range(0, 24) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
